// File: rtl/wb_arbiter_2m.sv
// Two-master / one-slave Wishbone arbiter with round-robin tie-break, full-cycle
// bus locking and a per-access watchdog that reports err to the owning master.
module wb_arbiter_2m #(
  parameter int AW      = 32,
  parameter int DW      = 128,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [AW-1:0]     i_m0_adr,
  input  logic [DW/8-1:0]   i_m0_sel,
  input  logic              i_m0_we,
  input  logic [DW-1:0]     i_m0_dat,
  input  logic              i_m0_cyc,
  input  logic              i_m0_stb,
  output logic [DW-1:0]     o_m0_dat,
  output logic              o_m0_ack,
  output logic              o_m0_err,
  input  logic [AW-1:0]     i_m1_adr,
  input  logic [DW/8-1:0]   i_m1_sel,
  input  logic              i_m1_we,
  input  logic [DW-1:0]     i_m1_dat,
  input  logic              i_m1_cyc,
  input  logic              i_m1_stb,
  output logic [DW-1:0]     o_m1_dat,
  output logic              o_m1_ack,
  output logic              o_m1_err,
  output logic [AW-1:0]     o_s_adr,
  output logic [DW/8-1:0]   o_s_sel,
  output logic              o_s_we,
  output logic [DW-1:0]     o_s_dat,
  output logic              o_s_cyc,
  output logic              o_s_stb,
  input  logic [DW-1:0]     i_s_dat,
  input  logic              i_s_ack,
  input  logic              i_s_err,
  output logic [1:0]        o_grant,
  output logic              o_busy
);

  localparam int WDW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WDW-1:0] WD_LAST = WDW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic           last_m1_q, last_m1_d;  // 1: m1 was the most recent owner
  logic [WDW-1:0] wd_q, wd_d;
  logic           wd_err;
  logic           own0, own1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= IDLE;
      last_m1_q <= 1'b1;
      wd_q      <= '0;
    end else begin
      state_q   <= state_d;
      last_m1_q <= last_m1_d;
      wd_q      <= wd_d;
    end
  end

  // Ownership ends only through IDLE, so every hand-over costs one dead cycle.
  always_comb begin
    state_d   = state_q;
    last_m1_d = last_m1_q;
    case (state_q)
      IDLE: begin
        if (i_m0_cyc && i_m1_cyc) begin
          state_d   = last_m1_q ? OWN0 : OWN1;
          last_m1_d = ~last_m1_q;
        end else if (i_m0_cyc) begin
          state_d   = OWN0;
          last_m1_d = 1'b0;
        end else if (i_m1_cyc) begin
          state_d   = OWN1;
          last_m1_d = 1'b1;
        end
      end
      OWN0:    if (!i_m0_cyc) state_d = IDLE;
      OWN1:    if (!i_m1_cyc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign own0 = (state_q == OWN0);
  assign own1 = (state_q == OWN1);

  // Handshake: a beat is offered while o_s_cyc & o_s_stb are high and completes
  // in the cycle the slave raises ack (or err); ack/err return combinationally.
  always_comb begin
    o_s_adr = '0;
    o_s_sel = '0;
    o_s_we  = 1'b0;
    o_s_dat = '0;
    o_s_cyc = 1'b0;
    o_s_stb = 1'b0;
    if (own0) begin
      o_s_adr = i_m0_adr;
      o_s_sel = i_m0_sel;
      o_s_we  = i_m0_we;
      o_s_dat = i_m0_dat;
      o_s_cyc = i_m0_cyc;
      o_s_stb = i_m0_stb;
    end else if (own1) begin
      o_s_adr = i_m1_adr;
      o_s_sel = i_m1_sel;
      o_s_we  = i_m1_we;
      o_s_dat = i_m1_dat;
      o_s_cyc = i_m1_cyc;
      o_s_stb = i_m1_stb;
    end
  end

  // Watchdog counts stalled strobe cycles; a slave response always wins.
  always_comb begin
    wd_d   = wd_q;
    wd_err = 1'b0;
    if (state_q == IDLE || i_s_ack || i_s_err) begin
      wd_d = '0;
    end else if (o_s_stb) begin
      if (TIMEOUT != 0 && wd_q == WD_LAST) begin
        wd_err = 1'b1;
        wd_d   = '0;
      end else begin
        wd_d = wd_q + WDW'(1);
      end
    end
  end

  assign o_m0_dat = i_s_dat;
  assign o_m1_dat = i_s_dat;
  assign o_m0_ack = i_s_ack & own0;
  assign o_m1_ack = i_s_ack & own1;
  assign o_m0_err = (i_s_err | wd_err) & own0;
  assign o_m1_err = (i_s_err | wd_err) & own1;
  assign o_grant  = {own1, own0};
  assign o_busy   = own0 | own1;

endmodule

// File: tb/tb_wb_arbiter_2m.sv
// Bench for wb_arbiter_2m: directed vector table, hand-written corner sequences
// and random traffic compared against an ownership/stall-count reference model.
module tb_wb_arbiter_2m;

  localparam int TO = 16;

  logic         i_clk;
  logic         i_rst_n;
  logic [31:0]  m_adr[2];
  logic [15:0]  m_sel[2];
  logic         m_we[2];
  logic [127:0] m_wdat[2];
  logic         m_cyc[2];
  logic         m_stb[2];
  logic [127:0] o_m0_dat, o_m1_dat;
  logic         o_m0_ack, o_m0_err, o_m1_ack, o_m1_err;
  logic [31:0]  o_s_adr;
  logic [15:0]  o_s_sel;
  logic         o_s_we, o_s_cyc, o_s_stb;
  logic [127:0] o_s_dat;
  logic [127:0] s_dat;
  logic         s_ack, s_err;
  logic [1:0]   o_grant;
  logic         o_busy;

  int checks = 0;
  int errors = 0;

  wb_arbiter_2m #(.AW(32), .DW(128), .TIMEOUT(TO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_m0_adr(m_adr[0]), .i_m0_sel(m_sel[0]), .i_m0_we(m_we[0]), .i_m0_dat(m_wdat[0]),
    .i_m0_cyc(m_cyc[0]), .i_m0_stb(m_stb[0]),
    .o_m0_dat(o_m0_dat), .o_m0_ack(o_m0_ack), .o_m0_err(o_m0_err),
    .i_m1_adr(m_adr[1]), .i_m1_sel(m_sel[1]), .i_m1_we(m_we[1]), .i_m1_dat(m_wdat[1]),
    .i_m1_cyc(m_cyc[1]), .i_m1_stb(m_stb[1]),
    .o_m1_dat(o_m1_dat), .o_m1_ack(o_m1_ack), .o_m1_err(o_m1_err),
    .o_s_adr(o_s_adr), .o_s_sel(o_s_sel), .o_s_we(o_s_we), .o_s_dat(o_s_dat),
    .o_s_cyc(o_s_cyc), .o_s_stb(o_s_stb),
    .i_s_dat(s_dat), .i_s_ack(s_ack), .i_s_err(s_err),
    .o_grant(o_grant), .o_busy(o_busy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  // ---------------- reference model ----------------
  // owner: 0/1 = master index, 2 = nobody; stall = consecutive unanswered strobes.
  int m_owner, m_last, m_stall;

  function automatic logic owner_stb();
    return (m_owner < 2) ? m_stb[m_owner] : 1'b0;
  endfunction

  function automatic logic wd_fire();
    return (TO > 0) && (m_owner < 2) && owner_stb() && !s_ack && !s_err
           && (m_stall == TO - 1);
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      m_owner <= 2;
      m_last  <= 1;
      m_stall <= 0;
    end else begin
      if (m_owner == 2 || s_ack || s_err) m_stall <= 0;
      else if (owner_stb()) m_stall <= wd_fire() ? 0 : m_stall + 1;
      if (m_owner == 2) begin
        if (m_cyc[0] && m_cyc[1]) begin
          m_owner <= 1 - m_last;
          m_last  <= 1 - m_last;
        end else if (m_cyc[0]) begin
          m_owner <= 0;
          m_last  <= 0;
        end else if (m_cyc[1]) begin
          m_owner <= 1;
          m_last  <= 1;
        end
      end else if (!m_cyc[m_owner]) begin
        m_owner <= 2;
      end
    end
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    logic [127:0] exp_q[$];
    logic [127:0] act_q[$];
    string        nm_q[$];
    logic         fire;
    fire = wd_fire();
    nm_q = '{"grant", "busy", "s_cyc", "s_stb", "s_we", "s_adr", "s_sel", "s_dat",
             "m0_ack", "m1_ack", "m0_err", "m1_err", "m0_dat", "m1_dat"};
    exp_q = '{};
    exp_q.push_back({126'd0, m_owner == 1, m_owner == 0});
    exp_q.push_back(128'(m_owner < 2));
    exp_q.push_back(128'((m_owner < 2) ? m_cyc[m_owner] : 1'b0));
    exp_q.push_back(128'(owner_stb()));
    exp_q.push_back(128'((m_owner < 2) ? m_we[m_owner] : 1'b0));
    exp_q.push_back(128'((m_owner < 2) ? m_adr[m_owner] : 32'd0));
    exp_q.push_back(128'((m_owner < 2) ? m_sel[m_owner] : 16'd0));
    exp_q.push_back((m_owner < 2) ? m_wdat[m_owner] : 128'd0);
    exp_q.push_back(128'(s_ack && m_owner == 0));
    exp_q.push_back(128'(s_ack && m_owner == 1));
    exp_q.push_back(128'((s_err || fire) && m_owner == 0));
    exp_q.push_back(128'((s_err || fire) && m_owner == 1));
    exp_q.push_back(s_dat);
    exp_q.push_back(s_dat);
    act_q = '{128'(o_grant), 128'(o_busy), 128'(o_s_cyc), 128'(o_s_stb), 128'(o_s_we),
              128'(o_s_adr), 128'(o_s_sel), o_s_dat, 128'(o_m0_ack), 128'(o_m1_ack),
              128'(o_m0_err), 128'(o_m1_err), o_m0_dat, o_m1_dat};
    for (int i = 0; i < nm_q.size(); i++) chk({"model_", nm_q[i]}, act_q[i], exp_q[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic half_check();
    @(negedge i_clk);
    check_model();
  endtask

  task automatic adv();
    @(posedge i_clk);
    #1;
  endtask

  task automatic set_master(input int n, input logic cyc, input logic stb);
    m_cyc[n] = cyc;
    m_stb[n] = stb;
  endtask

  task automatic idle_all();
    set_master(0, 1'b0, 1'b0);
    set_master(1, 1'b0, 1'b0);
    s_ack = 1'b0;
    s_err = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       c0, c1, ack, err;
    logic [1:0] exp_grant;
    logic       exp_s_cyc, exp_ack0, exp_ack1, exp_err0, exp_err1;
  } vec_t;

  vec_t vecs[14];

  initial begin
    // Tie from reset -> m0, hand-over to m1 via IDLE, m1 lock, then alternation.
    vecs[0]  = '{1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0};
    vecs[1]  = '{1, 1, 1, 0, 2'b01, 1, 1, 0, 0, 0};
    vecs[2]  = '{0, 1, 0, 0, 2'b01, 0, 0, 0, 0, 0};
    vecs[3]  = '{0, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0};
    vecs[4]  = '{0, 1, 1, 0, 2'b10, 1, 0, 1, 0, 0};
    vecs[5]  = '{1, 1, 0, 0, 2'b10, 1, 0, 0, 0, 0};
    vecs[6]  = '{1, 0, 0, 0, 2'b10, 0, 0, 0, 0, 0};
    vecs[7]  = '{1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0};
    vecs[8]  = '{1, 1, 0, 0, 2'b01, 1, 0, 0, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 2'b01, 0, 0, 0, 0, 0};
    vecs[10] = '{1, 1, 0, 0, 2'b00, 0, 0, 0, 0, 0};
    vecs[11] = '{1, 1, 1, 1, 2'b10, 1, 0, 1, 0, 1};
    vecs[12] = '{0, 0, 0, 1, 2'b10, 0, 0, 0, 0, 1};
    vecs[13] = '{0, 0, 1, 1, 2'b00, 0, 0, 0, 0, 0};
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] beef;
    beef = {96'h0123_4567_89AB_CDEF_0011_2233, 32'hDEAD_BEEF};
    for (int n = 0; n < 2; n++) begin
      m_adr[n] = '0; m_sel[n] = '0; m_we[n] = 1'b0; m_wdat[n] = '0;
    end
    idle_all();
    s_dat   = 128'h5555_AAAA_0000_FFFF_1234_5678_9ABC_DEF0;
    i_rst_n = 1'b0;
    repeat (2) @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    adv();

    // Reset state
    @(negedge i_clk);
    chk("reset_grant", 128'(o_grant), 128'd0);
    chk("reset_s_cyc", 128'(o_s_cyc), 128'd0);
    chk("reset_m0_dat", o_m0_dat, s_dat);
    adv();

    // Table: stb follows cyc
    m_adr[0] = 32'h1000; m_adr[1] = 32'h2000;
    for (int i = 0; i < 14; i++) begin
      set_master(0, vecs[i].c0, vecs[i].c0);
      set_master(1, vecs[i].c1, vecs[i].c1);
      s_ack = vecs[i].ack;
      s_err = vecs[i].err;
      half_check();
      chk($sformatf("vec%0d_grant", i), 128'(o_grant), 128'(vecs[i].exp_grant));
      chk($sformatf("vec%0d_s_cyc", i), 128'(o_s_cyc), 128'(vecs[i].exp_s_cyc));
      chk($sformatf("vec%0d_ack", i), 128'({o_m1_ack, o_m0_ack}),
          128'({vecs[i].exp_ack1, vecs[i].exp_ack0}));
      chk($sformatf("vec%0d_err", i), 128'({o_m1_err, o_m0_err}),
          128'({vecs[i].exp_err1, vecs[i].exp_err0}));
      adv();
    end
    idle_all();
    half_check(); adv();

    // Single master read, slave acks two cycles after grant
    m_adr[0] = 32'h0000_0100; m_we[0] = 1'b0; m_sel[0] = 16'hFFFF;
    for (int k = 0; k < 5; k++) begin
      set_master(0, k < 4, k < 4);
      s_ack = (k == 3);
      s_dat = (k == 3) ? beef : 128'd0;
      half_check();
      if (k == 1) chk("single_grant", 128'(o_grant), 128'b01);
      if (k == 3) begin
        chk("single_ack", 128'(o_m0_ack), 128'd1);
        chk("single_dat", o_m0_dat, beef);
      end
      chk("single_m1_ack", 128'(o_m1_ack), 128'd0);
      adv();
    end
    idle_all();
    half_check(); adv();

    // Lock: m1 runs a 4-beat burst while m0 keeps requesting
    for (int k = 0; k < 8; k++) begin
      set_master(1, k < 5, (k >= 1 && k <= 4));
      set_master(0, k >= 1, k >= 1);
      s_ack = (k >= 1 && k <= 4);
      half_check();
      chk($sformatf("lock_grant_k%0d", k), 128'(o_grant),
          (k == 0 || k == 6) ? 128'b00 : (k == 7) ? 128'b01 : 128'b10);
      adv();
    end
    idle_all();
    half_check(); adv();

    // Watchdog: repeated expiry, then ack landing on the expiry cycle
    for (int k = 0; k < 50; k++) begin
      set_master(0, 1'b1, 1'b1);
      s_ack = (k == 48);
      half_check();
      chk($sformatf("wd_err_k%0d", k), 128'(o_m0_err), 128'(k == 16 || k == 32));
      chk($sformatf("wd_ack_k%0d", k), 128'(o_m0_ack), 128'(k == 48));
      if (k >= 1) chk($sformatf("wd_s_cyc_k%0d", k), 128'(o_s_cyc), 128'd1);
      adv();
    end
    idle_all();
    half_check(); adv();

    // Asynchronous reset while m1 owns the bus
    set_master(1, 1'b1, 1'b1);
    half_check(); adv();
    half_check(); adv();
    s_ack = 1'b1;
    #2 i_rst_n = 1'b0;
    #1;
    chk("arst_s_cyc", 128'(o_s_cyc), 128'd0);
    chk("arst_s_stb", 128'(o_s_stb), 128'd0);
    chk("arst_grant", 128'(o_grant), 128'd0);
    chk("arst_m1_ack", 128'(o_m1_ack), 128'd0);
    @(posedge i_clk);
    #3 i_rst_n = 1'b1;
    s_ack = 1'b0;
    set_master(0, 1'b1, 1'b1);
    adv();
    half_check();
    chk("arst_tie_grant", 128'(o_grant), 128'b01);
    adv();
    idle_all();
    half_check(); adv();

    // Random traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int n = 0; n < 2; n++) begin
        if (m_cyc[n]) m_cyc[n] = ($urandom_range(0, 5) != 0);
        else          m_cyc[n] = ($urandom_range(0, 2) == 0);
        m_stb[n]  = m_cyc[n] && ($urandom_range(0, 3) != 0);
        m_we[n]   = 1'($urandom_range(0, 1));
        m_adr[n]  = $urandom;
        m_sel[n]  = 16'($urandom);
        m_wdat[n] = {$urandom, $urandom, $urandom, $urandom};
      end
      s_ack = ($urandom_range(0, 9) == 0);
      s_err = ($urandom_range(0, 31) == 0);
      s_dat = {$urandom, $urandom, $urandom, $urandom};
      half_check();
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
